// File: rtl/mem_stage_if.sv
// EX->M inputs and M-stage outputs of the memory stage.
// The stage itself is the slave; the EX/W side is the master.
interface mem_stage_if;
  logic [31:0] Instr_E;
  logic [31:0] ALUout_E;
  logic [31:0] RF_RD2_E;
  logic [31:0] PC8_E;
  logic        RegWrite_E;
  logic        ForwardRTM;
  logic [31:0] Write_data_W;
  logic [31:0] Instr_M;
  logic [31:0] ALUout_M;
  logic [31:0] PC8_M;
  logic [31:0] ReadData_M;
  logic [4:0]  WriteReg_M;
  logic        RegWrite_M;

  modport master (
    output Instr_E, ALUout_E, RF_RD2_E, PC8_E,
    output RegWrite_E, ForwardRTM, Write_data_W,
    input  Instr_M, ALUout_M, PC8_M,
    input  ReadData_M, WriteReg_M, RegWrite_M
  );

  modport slave (
    input  Instr_E, ALUout_E, RF_RD2_E, PC8_E,
    input  RegWrite_E, ForwardRTM, Write_data_W,
    output Instr_M, ALUout_M, PC8_M,
    output ReadData_M, WriteReg_M, RegWrite_M
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory stage: EX/MEM register, data memory,
// lw/lb/sw/sb and store-data forwarding from W.
module mem_stage #(
  parameter int DM_WORDS = 1024
) (
  input  logic         clk,
  input  logic         reset,
  mem_stage_if.slave   bus
);

  localparam int AW = $clog2(DM_WORDS);

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_JAL = 6'b000011;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [31:0] pc8;
    logic        rw;
  } ex_mem_t;

  ex_mem_t     m_q, m_d;
  logic [31:0] mem_q [DM_WORDS];

  logic [5:0]    op;
  logic          is_lw, is_lb, is_sw, is_sb;
  logic          is_r, is_jal;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   rword;
  logic [7:0]    rbyte;
  logic [31:0]   sd;
  logic [31:0]   wword;
  logic [31:0]   rdata;
  logic [4:0]    wreg;

  always_comb begin
    m_d.instr = bus.Instr_E;
    m_d.alu   = bus.ALUout_E;
    m_d.rd2   = bus.RF_RD2_E;
    m_d.pc8   = bus.PC8_E;
    m_d.rw    = bus.RegWrite_E;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) m_q <= '0;
    else        m_q <= m_d;
  end

  assign op     = m_q.instr[31:26];
  assign is_lw  = (op == OP_LW);
  assign is_lb  = (op == OP_LB);
  assign is_sw  = (op == OP_SW);
  assign is_sb  = (op == OP_SB);
  assign is_r   = (op == OP_R);
  assign is_jal = (op == OP_JAL);

  // Upper address bits are dropped: memory wraps every 4 KiB.
  assign idx   = m_q.alu[AW+1:2];
  assign lane  = m_q.alu[1:0];
  assign rword = mem_q[idx];
  assign sd    = bus.ForwardRTM ? bus.Write_data_W : m_q.rd2;

  always_comb begin
    rbyte = rword[7:0];
    wword = rword;
    unique case (lane)
      2'd0: begin rbyte = rword[7:0];   wword[7:0]   = sd[7:0]; end
      2'd1: begin rbyte = rword[15:8];  wword[15:8]  = sd[7:0]; end
      2'd2: begin rbyte = rword[23:16]; wword[23:16] = sd[7:0]; end
      2'd3: begin rbyte = rword[31:24]; wword[31:24] = sd[7:0]; end
      default: ;
    endcase
    if (is_sw) wword = sd;
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      is_lw:   rdata = rword;
      is_lb:   rdata = {{24{rbyte[7]}}, rbyte};
      default: ;
    endcase
  end

  always_comb begin
    wreg = m_q.instr[20:16];
    unique case (1'b1)
      is_r:    wreg = m_q.instr[15:11];
      is_jal:  wreg = 5'd31;
      default: ;
    endcase
    if (!m_q.rw) wreg = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              mem_q      <= '{default: '0};
    else if (is_sw || is_sb) mem_q[idx] <= wword;
  end

  assign bus.Instr_M    = m_q.instr;
  assign bus.ALUout_M   = m_q.alu;
  assign bus.PC8_M      = m_q.pc8;
  assign bus.RegWrite_M = m_q.rw;
  assign bus.WriteReg_M = wreg;
  assign bus.ReadData_M = rdata;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios then random
// traffic against a word-array reference model.
module tb_mem_stage;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] ref_mem [1024];

  mem_stage_if bus ();

  mem_stage #(.DM_WORDS(1024)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] SB  = 6'b101000;
  localparam logic [5:0] RT  = 6'b000000;
  localparam logic [5:0] JAL = 6'b000011;
  localparam logic [5:0] ADI = 6'b001000;

  function automatic logic [31:0] mk(
    input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rd);
    return {op, 5'd3, rt, rd, 11'h021};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected M outputs from the instruction's meaning, then the
  // store is applied to the model as it commits at the next edge.
  task automatic model_m(input logic [31:0] ins, alu, rd2, pc8,
                         input logic rw, fwd, input logic [31:0] wdw);
    int unsigned w, ln, b;
    logic [5:0]  op;
    logic [31:0] erd, sd;
    logic [4:0]  ewr;
    op  = ins[31:26];
    w   = (alu % 4096) / 4;
    ln  = alu % 4;
    b   = (ref_mem[w] >> (8 * ln)) & 255;
    erd = 0;
    if (op == LW) erd = ref_mem[w];
    if (op == LB) erd = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
    if (!rw)            ewr = 0;
    else if (op == RT)  ewr = ins[15:11];
    else if (op == JAL) ewr = 31;
    else                ewr = ins[20:16];
    chk("Instr_M", bus.Instr_M, ins);
    chk("ALUout_M", bus.ALUout_M, alu);
    chk("PC8_M", bus.PC8_M, pc8);
    chk("RegWrite_M", {31'd0, bus.RegWrite_M}, {31'd0, rw});
    chk("WriteReg_M", {27'd0, bus.WriteReg_M}, {27'd0, ewr});
    chk("ReadData_M", bus.ReadData_M, erd);
    sd = fwd ? wdw : rd2;
    if (op == SW) ref_mem[w] = sd;
    if (op == SB) ref_mem[w][8*ln +: 8] = sd[7:0];
  endtask

  task automatic step(input logic [31:0] ins, alu, rd2, pc8,
                      input logic rw, fwd, input logic [31:0] wdw);
    @(negedge clk);
    bus.Instr_E    = ins;
    bus.ALUout_E   = alu;
    bus.RF_RD2_E   = rd2;
    bus.PC8_E      = pc8;
    bus.RegWrite_E = rw;
    @(posedge clk);
    #1;
    bus.ForwardRTM   = fwd;
    bus.Write_data_W = wdw;
    #1;
    model_m(ins, alu, rd2, pc8, rw, fwd, wdw);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_Instr_M"}, bus.Instr_M, 0);
    chk({tag, "_ALUout_M"}, bus.ALUout_M, 0);
    chk({tag, "_PC8_M"}, bus.PC8_M, 0);
    chk({tag, "_RegWrite_M"}, {31'd0, bus.RegWrite_M}, 0);
    chk({tag, "_WriteReg_M"}, {27'd0, bus.WriteReg_M}, 0);
    chk({tag, "_ReadData_M"}, bus.ReadData_M, 0);
  endtask

  initial begin
    logic [5:0]  ops [7];
    logic [5:0]  op;
    logic [31:0] alu;
    ops = '{LW, LB, SW, SB, RT, JAL, ADI};
    for (int i = 0; i < 1024; i++) ref_mem[i] = 0;
    bus.Instr_E = 0; bus.ALUout_E = 0; bus.RF_RD2_E = 0;
    bus.PC8_E = 0; bus.RegWrite_E = 0;
    bus.ForwardRTM = 0; bus.Write_data_W = 0;

    #2;
    chk_zero("por");
    @(negedge clk);
    reset = 1'b1;

    // Word round trip.
    step(mk(SW, 5'd4, 5'd0), 32'h10, 32'hDEADBEEF, 32'h108, 0, 0, 0);
    chk("sw_wr", {27'd0, bus.WriteReg_M}, 0);
    step(mk(LW, 5'd5, 5'd0), 32'h10, 0, 32'h10C, 1, 0, 0);
    chk("lw_rt", bus.ReadData_M, 32'hDEADBEEF);

    // Byte store and sign extension.
    step(mk(SW, 5'd4, 5'd0), 32'h10, 32'h0, 32'h110, 0, 0, 0);
    step(mk(SB, 5'd4, 5'd0), 32'h12, 32'hF0, 32'h114, 0, 0, 0);
    step(mk(LW, 5'd6, 5'd0), 32'h10, 0, 32'h118, 1, 0, 0);
    chk("sb_word", bus.ReadData_M, 32'h00F00000);
    step(mk(LB, 5'd6, 5'd0), 32'h12, 0, 32'h11C, 1, 0, 0);
    chk("lb_neg", bus.ReadData_M, 32'hFFFFFFF0);
    step(mk(LB, 5'd6, 5'd0), 32'h11, 0, 32'h120, 1, 0, 0);
    chk("lb_zero", bus.ReadData_M, 32'h0);

    // Store-data forwarding from W.
    step(mk(SW, 5'd4, 5'd0), 32'h20, 32'h1111, 32'h124, 0, 1, 32'h2222);
    step(mk(LW, 5'd7, 5'd0), 32'h20, 0, 32'h128, 1, 0, 0);
    chk("fwd", bus.ReadData_M, 32'h2222);

    // Wrap and destination decode.
    step(mk(SW, 5'd4, 5'd0), 32'h10, 32'hA5A5_0001, 32'h12C, 0, 0, 0);
    step(mk(LW, 5'd8, 5'd0), 32'h1010, 0, 32'h130, 1, 0, 0);
    chk("wrap", bus.ReadData_M, 32'hA5A5_0001);
    step(mk(JAL, 5'd2, 5'd3), 32'h13C, 0, 32'h13C, 1, 0, 0);
    chk("jal_wr", {27'd0, bus.WriteReg_M}, 31);
    chk("jal_pc8", bus.PC8_M, 32'h13C);
    step(mk(RT, 5'd2, 5'd9), 32'h77, 0, 32'h140, 1, 0, 0);
    chk("r_wr", {27'd0, bus.WriteReg_M}, 9);

    // Reset while a store sits in M.
    step(mk(SW, 5'd4, 5'd0), 32'h14, 32'hCAFEF00D, 32'h144, 0, 0, 0);
    step(mk(LW, 5'd8, 5'd0), 32'h14, 0, 32'h148, 1, 0, 0);
    chk("pre_rst", bus.ReadData_M, 32'hCAFEF00D);
    @(negedge clk);
    bus.Instr_E = mk(SW, 5'd4, 5'd0);
    bus.ALUout_E = 32'h14; bus.RF_RD2_E = 32'h12345678;
    bus.RegWrite_E = 0;
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk_zero("rst");
    for (int i = 0; i < 1024; i++) ref_mem[i] = 0;
    @(negedge clk);
    reset = 1'b1;
    bus.Instr_E = 0; bus.ALUout_E = 0; bus.RF_RD2_E = 0;
    step(mk(LW, 5'd8, 5'd0), 32'h14, 0, 32'h200, 1, 0, 0);
    chk("rst_mem5", bus.ReadData_M, 32'h0);

    // Random traffic over a few words, with aliasing upper bits.
    for (int n = 0; n < 300; n++) begin
      op  = ops[$urandom_range(0, 6)];
      alu = ($urandom_range(0, 7) << 12) | ($urandom_range(0, 7) << 2)
            | $urandom_range(0, 3);
      step({op, 26'($urandom)}, alu, $urandom, $urandom,
           1'($urandom), 1'($urandom), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage MIPS pipeline, directly downstream of the execute stage. Holds the EX/MEM pipeline register, performs loads and stores against a 1024-word data memory, and produces the M-stage values the execute stage forwards from (`ALUout_M`) and the write-back stage consumes. Store data can be forwarded from write-back to resolve a load-then-store dependency.

## Interface
- `DM_WORDS`, 1024: data memory depth in 32-bit words; the word index is `addr[11:2]`.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears the pipeline register and all memory words.
- `Instr_E`  in  32  instruction leaving EX.
- `ALUout_E`  in  32  EX result: effective address for loads/stores, or PC+8 for `jal`.
- `RF_RD2_E`  in  32  forwarded rt value from EX (store data).
- `PC8_E`  in  32  PC+8 of the EX instruction.
- `RegWrite_E`  in  1  EX instruction writes the register file.
- `ForwardRTM`  in  1  1 = use `Write_data_W` as store data instead of the registered rt.
- `Write_data_W`  in  32  value being written back in W.
- `Instr_M`  out  32  registered instruction.
- `ALUout_M`  out  32  registered ALU result; the forwarding source for EX.
- `PC8_M`  out  32  registered PC+8.
- `ReadData_M`  out  32  load result; combinational from the registered address.
- `WriteReg_M`  out  5  destination register: rd for R-type, 31 for `jal`, rt otherwise, 0 when `RegWrite_M`=0.
- `RegWrite_M`  out  1  registered `RegWrite_E`.

## Operation
- Pipeline register: on each rising edge it latches `Instr_E`, `ALUout_E`, `RF_RD2_E`, `PC8_E` and `RegWrite_E`. There is no stall or enable; a bubble is an all-zero instruction with `RegWrite_E`=0.
- Decode uses `Instr_M[31:26]` (op).
  - lw 100011, lb 100000, sw 101011, sb 101000.
  - R-type is op 000000; jal is 000011.
- Address: `a = ALUout_M`, word index `a[11:2]`, byte lane `a[1:0]`. Bits above 11 are ignored, so addresses wrap modulo 4 KiB. `a[1:0]` is ignored for word accesses; there is no misalignment trap.
- Store data `sd` = `ForwardRTM ? Write_data_W : RF_RD2_M`.
- sw: at the rising edge ending the M cycle, `mem[a[11:2]] <= sd`.
- sb: at the same edge, only byte lane `a[1:0]` is written, with `sd[7:0]`. Lane 0 is bits [7:0] and lane 3 is bits [31:24]; the other lanes are unchanged.
- lw: `ReadData_M = mem[a[11:2]]`.
- lb: `ReadData_M` = the selected byte, sign-extended to 32 bits.
- All other ops: `ReadData_M` = 0, and memory is not written.
- `WriteReg_M`: R-type → `Instr_M[15:11]`; jal → 31; else → `Instr_M[20:16]`. Forced to 0 when `RegWrite_M`=0.

## Timing
- Reset asserted (low), at any time including mid-store: all registered outputs and every memory word go to 0 immediately. `Instr_M`=0, `ALUout_M`=0, `PC8_M`=0, `RegWrite_M`=0, `WriteReg_M`=0, `ReadData_M`=0.
- A store in progress when reset asserts is lost. The first edge after reset deasserts loads the EX values normally.
- Latency: EX values appear on M outputs 1 cycle after the capturing edge. `ReadData_M` is valid within the same M cycle (combinational read, 0 additional cycles).
- Store commit happens at the edge that ends the store's M cycle.
  - A load in the very next M cycle to the same word sees the new value.
  - A load in the same cycle as the store cannot occur, since there is one instruction per stage.
- `ForwardRTM` and `Write_data_W` are sampled combinationally during the M cycle; the value present at the commit edge is the one stored.
- Memory writes happen only for sw/sb with reset high.

## Test plan
- Reset: load nonzero values into memory, then pull `reset` low between clock edges → all outputs are 0 immediately and `mem[5]` reads 0 via a subsequent lw to address 0x14.
- Word round trip: sw with `ALUout_E`=0x10 and `RF_RD2_E`=0xDEADBEEF, followed by lw with address 0x10 → in the lw's M cycle, `ReadData_M`=0xDEADBEEF.
- Byte store and sign extension: start with word 0x10 = 0x00000000, then sb to address 0x12 with data 0x000000F0 → word = 0x00F00000. A following lb from 0x12 → 0xFFFFFFF0; lb from 0x11 → 0x00000000.
- Store-data forwarding: sw to 0x20 with `RF_RD2_E`=0x1111, `ForwardRTM`=1, `Write_data_W`=0x2222 → a subsequent lw from 0x20 returns 0x2222.
- Wrap and destination decode: lw from 0x1010 reads the same word as 0x10. jal with `RegWrite_E`=1 → `WriteReg_M`=31 and `PC8_M` passed through. An R-type with rd=9 → `WriteReg_M`=9. sw → `WriteReg_M`=0.
